// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: round control FSM for an iterative AES core; AES_SEQ_ABORT_EN adds abort/aborted.
module aes_round_sequencer #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             decrypt,
`ifdef AES_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             ready,
  output logic             load_state,
  output logic             round_en,
  output logic             final_round,
  output logic [IDX_W-1:0] key_idx,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             err_mode,
  output logic [CNT_W-1:0] blocks_done
);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] r_q, r_d, nr_q, nr_d, key_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dec_q, dec_d, err_d, kill;
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    nr_d = nr_q;
    dec_d = dec_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    kill = abort && (state_q == LOAD || state_q == ROUND);
`else
    kill = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        if (mode == 2'b11) err_d = 1'b1;
        else begin
          state_d = LOAD;
          dec_d = decrypt;
          nr_d = (mode == 2'b00) ? IDX_W'(10) : (mode == 2'b01) ? IDX_W'(12) : IDX_W'(14);
        end
      end
      LOAD: begin
        state_d = ROUND;
        r_d = IDX_W'(1);
      end
      ROUND: if (r_q == nr_q) state_d = DONE; else r_d = r_q + IDX_W'(1);
      DONE: if (done_ready) begin
        state_d = IDLE;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      r_d = '0;
    end
    // outputs are registered, so decode them from the next state
    key_idx_d = (state_d == LOAD) ? (dec_d ? nr_d : '0) :
                (state_d == ROUND) ? (dec_d ? nr_d - r_d : r_d) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q <= '0;
      nr_q <= '0;
      dec_q <= 1'b0;
      cnt_q <= '0;
      ready <= 1'b1;
      load_state <= 1'b0;
      round_en <= 1'b0;
      final_round <= 1'b0;
      key_idx <= '0;
      done_valid <= 1'b0;
      err_mode <= 1'b0;
`ifdef AES_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      nr_q <= nr_d;
      dec_q <= dec_d;
      cnt_q <= cnt_d;
      ready <= state_d == IDLE;
      load_state <= state_d == LOAD;
      round_en <= state_d == ROUND;
      final_round <= state_d == ROUND && r_d == nr_d;
      key_idx <= key_idx_d;
      done_valid <= state_d == DONE;
      err_mode <= err_d;
`ifdef AES_SEQ_ABORT_EN
      aborted <= kill;
`endif
    end
  end
  assign blocks_done = cnt_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: scoreboard bench; expected datapath events queued at issue, checked by a monitor.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic reset, start, decrypt, done_ready;
  logic [1:0] mode;
  logic ready, load_state, round_en, final_round, done_valid, err_mode;
  logic [3:0] key_idx;
  logic [7:0] blocks_done;
`ifdef AES_SEQ_ABORT_EN
  logic abort, aborted;
`endif

  aes_round_sequencer #(.IDX_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .decrypt(decrypt),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .ready(ready), .load_state(load_state), .round_en(round_en),
    .final_round(final_round), .key_idx(key_idx), .done_valid(done_valid),
    .done_ready(done_ready), .err_mode(err_mode), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  // kind: 0 load, 1 round, 2 done (rising), 3 err; cnt -1 means don't care
  typedef struct {int kind; int cyc; int idx; int fin; int cnt;} ev_t;
  ev_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [7:0] exp_cnt;
  logic prev_dv = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nr_of(input int m);
    return m == 0 ? 10 : m == 1 ? 12 : 14;
  endfunction

  initial forever begin
    ev_t e;
    int kind;
    @(posedge clk);
    cyc++;
    #1;
    chk("exclusive", ((int'(load_state) + int'(round_en) + int'(done_valid)) > 1 || (final_round && !round_en)) ? 1 : 0, 0);
    if (load_state || round_en || (done_valid && !prev_dv) || err_mode) begin
      kind = err_mode ? 3 : load_state ? 0 : round_en ? 1 : 2;
      if (sb.size() == 0) chk("unexpected_event", kind, -1);
      else begin
        e = sb.pop_front();
        checks++;
        if (e.kind != kind || e.cyc != cyc || e.idx != int'(key_idx) || e.fin != int'(final_round) ||
            (e.cnt >= 0 && e.cnt != int'(blocks_done))) begin
          errors++;
          $display("FAIL event got kind %0d cyc %0d idx %0d fin %0d cnt %0d expected kind %0d cyc %0d idx %0d fin %0d cnt %0d",
                   kind, cyc, key_idx, final_round, blocks_done, e.kind, e.cyc, e.idx, e.fin, e.cnt);
        end
      end
    end
    prev_dv = done_valid;
  end

  task automatic issue(input int m, input bit d, output int e);
    int w = 0;
    int nr;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("ready_timeout", 0, 1);
    start = 1'b1;
    mode = 2'(m);
    decrypt = d;
    e = cyc + 1;
    nr = nr_of(m);
    sb.push_back('{0, e, d ? nr : 0, 0, -1});
    for (int i = 1; i <= nr; i++) sb.push_back('{1, e + i, d ? nr - i : i, (i == nr) ? 1 : 0, -1});
    sb.push_back('{2, e + nr + 1, 0, 0, int'(exp_cnt)});
    exp_cnt++;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom);
    decrypt = 1'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e, pe, w;
    logic [7:0] c;
    reset = 1'b1; start = 1'b0; mode = 2'b00; decrypt = 1'b0; done_ready = 1'b1; exp_cnt = 8'd0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_load", int'(load_state), 0);
    chk("rst_round", int'(round_en), 0);
    chk("rst_final", int'(final_round), 0);
    chk("rst_done", int'(done_valid), 0);
    chk("rst_err", int'(err_mode), 0);
    chk("rst_idx", int'(key_idx), 0);
    chk("rst_cnt", int'(blocks_done), 0);
    reset = 1'b0;
    @(negedge clk);
    // 128-bit encrypt
    issue(0, 0, e);
    repeat (12) @(negedge clk);
    chk("t1_cnt", int'(blocks_done), 1);
    chk("t1_ready", int'(ready), 1);
    // 256 decrypt, 192 encrypt
    issue(2, 1, e);
    issue(1, 0, e);
    repeat (15) @(negedge clk);
    chk("t2_cnt", int'(blocks_done), int'(exp_cnt));
    // illegal mode
    start = 1'b1; mode = 2'b11; decrypt = 1'b0;
    e = cyc + 1;
    sb.push_back('{3, e, 0, 0, -1});
    @(negedge clk);
    start = 1'b0;
    chk("t3_ready", int'(ready), 1);
    chk("t3_load", int'(load_state), 0);
    @(negedge clk);
    chk("t3_err_off", int'(err_mode), 0);
    chk("t3_ready2", int'(ready), 1);
    chk("t3_cnt", int'(blocks_done), int'(exp_cnt));
    // done held while start toggles
    done_ready = 1'b0;
    issue(0, 0, e);
    w = 0;
    while (!done_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t4_done_seen", int'(done_valid), 1);
    c = blocks_done;
    for (int i = 0; i < 5; i++) begin
      start = ~start;
      mode = 2'b00;
      @(negedge clk);
      chk("t4_hold_done", int'(done_valid), 1);
      chk("t4_no_load", int'(load_state), 0);
      chk("t4_cnt_hold", int'(blocks_done), int'(c));
    end
    start = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    chk("t4_cnt_inc", int'(blocks_done), int'(8'(c + 8'd1)));
    chk("t4_ready", int'(ready), 1);
    // reset in ROUND at r=5
    issue(0, 0, e);
    while (cyc < e + 5) @(negedge clk);
    chk("t5_r5", int'(key_idx), 5);
    reset = 1'b1;
    sb.delete();
    exp_cnt = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_ready", int'(ready), 1);
    chk("t5_round", int'(round_en), 0);
    chk("t5_done", int'(done_valid), 0);
    chk("t5_cnt", int'(blocks_done), 0);
    issue(1, 1, e);
    repeat (15) @(negedge clk);
    chk("t5_after", int'(blocks_done), 1);
    // 256 back-to-back blocks, counter wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 8'd0;
    pe = 0;
    for (int k = 0; k < 256; k++) begin
      issue(0, 0, e);
      if (k > 0) chk("t6_spacing", e - pe, 13);
      pe = e;
    end
    repeat (14) @(negedge clk);
    chk("t6_wrap", int'(blocks_done), 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
